// File: rtl/char_sprite_pkg.sv
// Shared constants and types for the character sprite line fetcher.
package char_sprite_pkg;

    localparam int SPRITE_W = 41;
    localparam int SPRITE_H = 65;
    localparam int ADDR_W   = 12;
    localparam int COL_W    = $clog2(SPRITE_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } fetch_state_t;

    typedef logic [3:0] pal_idx_t;

endpackage

// File: rtl/char_rom_if.sv
// Sprite frame ROM read bus: address out from the fetcher, palette index back same cycle.
interface char_rom_if;
    import char_sprite_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    pal_idx_t          rom_idx;

    modport master (output rom_addr, input rom_idx);
    modport slave  (input rom_addr, output rom_idx);
endinterface

// File: rtl/char_line_buffer.sv
// One sprite row of palette indices: synchronous write, asynchronous read.
module char_line_buffer
    import char_sprite_pkg::*;
(
    input  logic             Clk,
    input  logic             we_i,
    input  logic [COL_W-1:0] waddr_i,
    input  pal_idx_t         wdata_i,
    input  logic [COL_W-1:0] raddr_i,
    output pal_idx_t         rdata_o
);

    pal_idx_t mem_q [SPRITE_W];

    // Row storage; contents are only trusted once a full fetch completes.
    always_ff @(posedge Clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end else begin
            mem_q[waddr_i] <= mem_q[waddr_i];
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/char_line_fetcher.sv
// Fetches one sprite row per scanline into a line buffer and replays it against DrawX.
// Optional horizontal mirroring is enabled by defining CHAR_MIRROR_EN (adds the flip input).
module char_line_fetcher
    import char_sprite_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        line_start,
    input  logic [9:0]  next_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  Char_X,
    input  logic [9:0]  Char_Y,
    char_rom_if.master  rom,
    output logic        pixel_on,
    output pal_idx_t    lut_idx,
    output logic        fetch_busy
`ifdef CHAR_MIRROR_EN
    ,
    input  logic        flip
`endif
);

    fetch_state_t      state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [6:0]        row_q, row_d;
    logic [9:0]        x0_q, x0_d;
    logic              line_valid_q, line_valid_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              flip_q, flip_d;
    logic              fetch_busy_q;
    logic              pixel_on_q, pixel_on_d;
    pal_idx_t          lut_idx_q, lut_idx_d;

    logic [10:0]       row_s, dx_s;
    logic              row_ok_s, show_s, buf_we_s;
    logic [COL_W-1:0]  wr_col_s, rd_col_s;
    pal_idx_t          rd_data_s;

`ifdef CHAR_MIRROR_EN
    assign flip_d   = line_start ? flip : flip_q;
    assign wr_col_s = flip_q ? (COL_W'(SPRITE_W - 1) - col_q) : col_q;
`else
    assign flip_d   = 1'b0;
    assign wr_col_s = col_q;
`endif

    // Next-state logic: line_start always wins, so a mid-fetch pulse restarts from column 0.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        x0_d         = x0_q;
        line_valid_d = line_valid_q;
        rom_addr_d   = rom_addr_q;
        buf_we_s     = 1'b0;
        row_s        = {1'b0, next_y} - {1'b0, Char_Y};
        row_ok_s     = (row_s[10] == 1'b0) && (row_s < 11'(SPRITE_H));
        if (line_start) begin
            x0_d         = Char_X;
            line_valid_d = 1'b0;
            col_d        = '0;
            if (row_ok_s) begin
                row_d   = row_s[6:0];
                state_d = FETCH;
            end else begin
                state_d = READY;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    buf_we_s = 1'b1;
                    if (col_q == COL_W'(SPRITE_W - 1)) begin
                        state_d      = READY;
                        line_valid_d = 1'b1;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                IDLE, READY: begin
                    state_d = state_q;
                end
                default: begin
                    state_d      = IDLE;
                    line_valid_d = 1'b0;
                end
            endcase
        end
        if (state_d == FETCH) begin
            rom_addr_d = ADDR_W'(row_d) * ADDR_W'(SPRITE_W) + ADDR_W'(col_d);
        end else begin
            rom_addr_d = rom_addr_q;
        end
    end

    // Pixel path: the buffer is hidden while it is being rewritten.
    always_comb begin
        dx_s     = {1'b0, DrawX} - {1'b0, x0_q};
        show_s   = line_valid_q && (state_q != FETCH) &&
                   (dx_s[10] == 1'b0) && (dx_s < 11'(SPRITE_W));
        rd_col_s = show_s ? dx_s[COL_W-1:0] : '0;
        if (show_s) begin
            lut_idx_d  = rd_data_s;
            pixel_on_d = (rd_data_s != 4'd0);
        end else begin
            lut_idx_d  = 4'd0;
            pixel_on_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= 7'd0;
            x0_q         <= 10'd0;
            line_valid_q <= 1'b0;
            rom_addr_q   <= '0;
            flip_q       <= 1'b0;
            fetch_busy_q <= 1'b0;
            pixel_on_q   <= 1'b0;
            lut_idx_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            x0_q         <= x0_d;
            line_valid_q <= line_valid_d;
            rom_addr_q   <= rom_addr_d;
            flip_q       <= flip_d;
            fetch_busy_q <= (state_d == FETCH);
            pixel_on_q   <= pixel_on_d;
            lut_idx_q    <= lut_idx_d;
        end
    end

    char_line_buffer u_buf (
        .Clk     (Clk),
        .we_i    (buf_we_s),
        .waddr_i (wr_col_s),
        .wdata_i (rom.rom_idx),
        .raddr_i (rd_col_s),
        .rdata_o (rd_data_s)
    );

    assign rom.rom_addr = rom_addr_q;
    assign pixel_on     = pixel_on_q;
    assign lut_idx      = lut_idx_q;
    assign fetch_busy   = fetch_busy_q;

endmodule

// File: tb/tb_char_line_fetcher.sv
// Directed scoreboard bench for char_line_fetcher; mirror test runs when CHAR_MIRROR_EN is defined.
module tb_char_line_fetcher;
    import char_sprite_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       line_start;
    logic [9:0] next_y, DrawX, Char_X, Char_Y;
    logic       pixel_on, fetch_busy;
    pal_idx_t   lut_idx;
`ifdef CHAR_MIRROR_EN
    logic       flip;
`endif

    int checks   = 0;
    int failures = 0;

    logic [11:0] addr_q [$];
    logic [4:0]  pix_q  [$];
    logic [3:0]  exp_buf [41];
    logic        tb_valid = 1'b0;
    int          tb_x0    = 0;

    char_rom_if rom_bus ();

    function automatic logic [3:0] rom_val(input logic [11:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8];
    endfunction

    assign rom_bus.rom_idx = rom_val(rom_bus.rom_addr);

    always #5 Clk = ~Clk;

    char_line_fetcher dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .next_y     (next_y),
        .DrawX      (DrawX),
        .Char_X     (Char_X),
        .Char_Y     (Char_Y),
        .rom        (rom_bus.master),
        .pixel_on   (pixel_on),
        .lut_idx    (lut_idx),
        .fetch_busy (fetch_busy)
`ifdef CHAR_MIRROR_EN
        ,
        .flip       (flip)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_pix(input int x);
        int dx;
        dx = x - tb_x0;
        if (tb_valid && dx >= 0 && dx < SPRITE_W) return {exp_buf[dx] != 4'd0, exp_buf[dx]};
        return 5'd0;
    endfunction

    // Issue line_start now (caller sits on a negedge) and follow ncyc fetch cycles.
    task automatic do_line(input int ny, input int cy, input int cx, input logic fl, input int ncyc);
        int  row;
        logic ok;
        row = ny - cy;
        ok  = (row >= 0) && (row < SPRITE_H);
        line_start = 1'b1;
        next_y = 10'(ny);
        Char_Y = 10'(cy);
        Char_X = 10'(cx);
        DrawX  = 10'(cx + 10);
`ifdef CHAR_MIRROR_EN
        flip = fl;
`endif
        tb_valid = 1'b0;
        tb_x0    = cx;
        addr_q.delete();
        if (ok) begin
            for (int c = 0; c < SPRITE_W; c++) addr_q.push_back(12'(row * SPRITE_W + c));
        end
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge Clk);
            line_start = 1'b0;
            if (ok) begin
                chk("fetch_busy", 16'(fetch_busy), 16'(1));
                chk("rom_addr", 16'(rom_bus.rom_addr), 16'(addr_q.pop_front()));
                if (k >= 2) chk("pix_during_fetch", 16'(pixel_on), 16'(0));
            end else begin
                chk("busy_no_fetch", 16'(fetch_busy), 16'(0));
            end
        end
        if (ok && ncyc == SPRITE_W) begin
            @(negedge Clk);
            chk("busy_done", 16'(fetch_busy), 16'(0));
            chk("addr_hold", 16'(rom_bus.rom_addr), 16'(row * SPRITE_W + SPRITE_W - 1));
            for (int c = 0; c < SPRITE_W; c++) begin
                if (fl) exp_buf[SPRITE_W - 1 - c] = rom_val(12'(row * SPRITE_W + c));
                else    exp_buf[c] = rom_val(12'(row * SPRITE_W + c));
            end
            tb_valid = 1'b1;
        end
    endtask

    // Sweep DrawX; each expectation is queued on drive and compared one cycle later.
    task automatic scan(input int lo, input int hi);
        logic [4:0] e;
        for (int x = lo; x <= hi; x++) begin
            DrawX = 10'(x);
            pix_q.push_back(model_pix(x));
            @(negedge Clk);
            e = pix_q.pop_front();
            chk("pixel", 16'({pixel_on, lut_idx}), 16'(e));
        end
    endtask

    initial begin
        Reset = 1'b1; line_start = 1'b0;
        next_y = 10'd0; DrawX = 10'd0; Char_X = 10'd0; Char_Y = 10'd0;
`ifdef CHAR_MIRROR_EN
        flip = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        chk("rst_rom_addr", 16'(rom_bus.rom_addr), 16'(0));
        chk("rst_pixel_on", 16'(pixel_on), 16'(0));
        chk("rst_lut_idx", 16'(lut_idx), 16'(0));
        chk("rst_busy", 16'(fetch_busy), 16'(0));
        Reset = 1'b0;
        @(negedge Clk);

        do_line(100, 100, 200, 1'b0, 41);
        scan(195, 245);

        do_line(164, 100, 200, 1'b0, 41);
        scan(198, 242);
        do_line(165, 100, 200, 1'b0, 2);
        scan(198, 242);

        do_line(99, 100, 200, 1'b0, 2);
        scan(199, 241);

        do_line(100, 100, 200, 1'b0, 20);
        do_line(110, 100, 200, 1'b0, 41);
        scan(198, 242);

        Char_X = 10'd300;
        scan(195, 245);
        scan(298, 342);
        do_line(101, 100, 300, 1'b0, 41);
        scan(295, 345);
        scan(198, 242);

`ifdef CHAR_MIRROR_EN
        do_line(100, 100, 200, 1'b1, 41);
        scan(199, 241);
`endif

        do_line(120, 100, 200, 1'b0, 10);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        tb_valid = 1'b0;
        tb_x0    = 0;
        chk("midrst_busy", 16'(fetch_busy), 16'(0));
        chk("midrst_addr", 16'(rom_bus.rom_addr), 16'(0));
        chk("midrst_pix", 16'(pixel_on), 16'(0));
        scan(195, 245);
        do_line(120, 100, 200, 1'b0, 41);
        scan(195, 245);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
